// File: rtl/mdu_iter_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// ALU op codes, FSM states and the default datapath width.
package mdu_iter_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_MUL = 4'b0100;
  localparam logic [3:0] ALU_MOV = 4'b0101;
  localparam logic [3:0] ALU_DIV = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_step.sv
// One iteration of unsigned shift-add multiply or
// restoring divide; purely combinational.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o
);

  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Remainder is shifted with the next dividend bit; the
  // difference fits WIDTH bits whenever it is kept.
  assign sh   = {acc_i, a_i[WIDTH-1]};
  assign ge   = sh >= {1'b0, b_i};
  assign diff = sh[WIDTH-1:0] - b_i;

  always_comb begin
    acc_o = acc_i;
    a_o   = a_i;
    b_o   = b_i;
    if (div_i) begin
      acc_o = ge ? diff : sh[WIDTH-1:0];
      a_o   = {a_i[WIDTH-2:0], ge};
    end else begin
      acc_o = acc_i + (b_i[0] ? a_i : '0);
      a_o   = a_i << 1;
      b_o   = b_i >> 1;
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MUL/DIV unit: WIDTH iterations per op,
// busy while working, one-cycle done pulse.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Rem,
  output logic [1:0]       ALUFlags,
  output logic             DivZero
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             div_q;
  logic [WIDTH-1:0] acc_q, a_q, b_q;
  logic [WIDTH-1:0] res_q, rem_q;
  logic [1:0]       flg_q;
  logic             dz_q;

  logic [WIDTH-1:0] acc_n, a_n, b_n;
  logic [WIDTH-1:0] res_d, rem_d;
  logic             is_mul, is_div;

  assign is_mul = ALUControl == ALU_MUL;
  assign is_div = ALUControl == ALU_DIV;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .div_i (div_q),
    .acc_i (acc_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .acc_o (acc_n),
    .a_o   (a_n),
    .b_o   (b_n)
  );

  // Final iteration output feeds the result registers.
  assign res_d = div_q ? a_n : acc_n;
  assign rem_d = div_q ? acc_n : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      rem_q   <= '0;
      flg_q   <= 2'b00;
      dz_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && (is_mul || is_div)) begin
            div_q <= is_div;
            acc_q <= '0;
            a_q   <= SrcA;
            b_q   <= SrcB;
            cnt_q <= '0;
            dz_q  <= 1'b0;
            if (is_div && SrcB == '0) begin
              res_q   <= '1;
              rem_q   <= SrcA;
              flg_q   <= 2'b10;
              dz_q    <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          acc_q <= acc_n;
          a_q   <= a_n;
          b_q   <= b_n;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            res_q   <= res_d;
            rem_q   <= rem_d;
            flg_q   <= {res_d[WIDTH-1], res_d == '0};
            state_q <= S_DONE;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = state_q != S_IDLE;
  assign done     = state_q == S_DONE;
  assign Result   = res_q;
  assign Rem      = rem_q;
  assign ALUFlags = flg_q;
  assign DivZero  = dz_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed-vector bench for mdu_iter.
// Each scenario task checks its own expected values.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ALUControl;
  logic [31:0] SrcA, SrcB;
  logic        busy, done;
  logic [31:0] Result, Rem;
  logic [1:0]  ALUFlags;
  logic        DivZero;

  int n_chk = 0;
  int n_fail = 0;

  mdu_iter dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .busy       (busy),
    .done       (done),
    .Result     (Result),
    .Rem        (Rem),
    .ALUFlags   (ALUFlags),
    .DivZero    (DivZero)
  );

  always #5 clk = ~clk;

  // Issue one op; lat = edges after the start edge at which
  // done is first seen (-1 on timeout). bsy_ok flags busy gaps.
  task automatic run_op(input logic [3:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        output int lat,
                        output logic bsy_ok);
    @(negedge clk);
    ALUControl = op; SrcA = a; SrcB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    bsy_ok = 1'b1;
    for (int e = 0; e < 60; e++) begin
      if (busy !== 1'b1) bsy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = e;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_after_done(input string nm);
    @(posedge clk); #1;
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_pulse: done=%b busy=%b want 0 0",
               nm, done, busy);
    end
  endtask

  task automatic chk_res(input string nm,
                         input logic [31:0] r,
                         input logic [31:0] m,
                         input logic [1:0] f,
                         input logic dz);
    n_chk++;
    if (Result !== r || Rem !== m || ALUFlags !== f ||
        DivZero !== dz) begin
      n_fail++;
      $display("FAIL %s: got R=%h Rem=%h F=%b DZ=%b want R=%h Rem=%h F=%b DZ=%b",
               nm, Result, Rem, ALUFlags, DivZero, r, m, f, dz);
    end
  endtask

  task automatic chk_lat(input string nm, input int lat,
                         input logic bsy_ok, input int want);
    n_chk++;
    if (lat !== want || bsy_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_lat: got %0d busy_ok=%b want %0d busy_ok=1",
               nm, lat, bsy_ok, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    ALUControl = 4'b0000; SrcA = '0; SrcB = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || Result !== 32'h0 ||
        Rem !== 32'h0 || ALUFlags !== 2'b00 || DivZero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b R=%h Rem=%h F=%b DZ=%b want all 0",
               busy, done, Result, Rem, ALUFlags, DivZero);
    end
    @(negedge clk);
    ALUControl = 4'b0010; SrcA = 32'd5; SrcB = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_op: busy=%b done=%b want 0 0", busy, done);
    end
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_op_later: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_mul();
    int lat; logic ok;
    run_op(4'b0100, 32'd7, 32'd6, lat, ok);
    chk_lat("mul_7x6", lat, ok, 32);
    chk_res("mul_7x6", 32'd42, 32'd0, 2'b00, 1'b0);
    chk_after_done("mul_7x6");
  endtask

  task automatic test_mul_edges();
    int lat; logic ok;
    run_op(4'b0100, 32'h8000_0000, 32'd3, lat, ok);
    chk_lat("mul_sign", lat, ok, 32);
    chk_res("mul_sign", 32'h8000_0000, 32'd0, 2'b10, 1'b0);
    chk_after_done("mul_sign");
    run_op(4'b0100, 32'h0001_0000, 32'h0001_0000, lat, ok);
    chk_lat("mul_ovf", lat, ok, 32);
    chk_res("mul_ovf", 32'h0, 32'd0, 2'b01, 1'b0);
    chk_after_done("mul_ovf");
  endtask

  task automatic test_div();
    int lat; logic ok;
    run_op(4'b0111, 32'd100, 32'd7, lat, ok);
    chk_lat("div_100_7", lat, ok, 32);
    chk_res("div_100_7", 32'd14, 32'd2, 2'b00, 1'b0);
    chk_after_done("div_100_7");
    run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, lat, ok);
    chk_lat("div_max_1", lat, ok, 32);
    chk_res("div_max_1", 32'hFFFF_FFFF, 32'd0, 2'b10, 1'b0);
    chk_after_done("div_max_1");
  endtask

  task automatic test_divzero();
    int lat; logic ok;
    run_op(4'b0111, 32'd55, 32'd0, lat, ok);
    chk_lat("div0", lat, ok, 0);
    chk_res("div0", 32'hFFFF_FFFF, 32'd55, 2'b10, 1'b1);
    chk_after_done("div0");
    chk_res("div0_hold", 32'hFFFF_FFFF, 32'd55, 2'b10, 1'b1);
    @(negedge clk);
    ALUControl = 4'b0100; SrcA = 32'd2; SrcB = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_chk++;
    if (DivZero !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL div0_clear: DZ=%b busy=%b want 0 1", DivZero, busy);
    end
    for (int i = 0; i < 60 && done !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    chk_res("mul_after_div0", 32'd4, 32'd0, 2'b00, 1'b0);
    chk_after_done("mul_after_div0");
  endtask

  task automatic test_busy_ignore();
    int lat = -1;
    @(negedge clk);
    ALUControl = 4'b0100; SrcA = 32'd9; SrcB = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    ALUControl = 4'b0111; SrcA = 32'd1000; SrcB = 32'd0;
    for (int e = 0; e < 60; e++) begin
      if (done === 1'b1) begin
        lat = e;
        break;
      end
      SrcA = SrcA + 32'd13;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk_lat("ignore", lat, 1'b1, 32);
    chk_res("ignore", 32'd81, 32'd0, 2'b00, 1'b0);
    chk_after_done("ignore");
  endtask

  task automatic test_reset_abort();
    logic seen = 1'b0;
    @(negedge clk);
    ALUControl = 4'b0111; SrcA = 32'd1000; SrcB = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || Result !== 32'h0 ||
        Rem !== 32'h0 || ALUFlags !== 2'b00 || DivZero !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: busy=%b done=%b R=%h Rem=%h F=%b DZ=%b want all 0",
               busy, done, Result, Rem, ALUFlags, DivZero);
    end
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_chk++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_quiet: activity=%b want 0", seen);
    end
    begin
      int lat; logic ok;
      run_op(4'b0100, 32'd3, 32'd5, lat, ok);
      chk_lat("mul_3x5", lat, ok, 32);
      chk_res("mul_3x5", 32'd15, 32'd0, 2'b00, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mul_edges();
    test_div();
    test_divzero();
    test_busy_ignore();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit that sits directly downstream of the decode stage.
- Consumes the ALUControl encodings for MUL (4'b0100) and DIV (4'b0111) together with the two register operands, and produces a 32-bit result plus N/Z flags.
- Raises busy so the main FSM holds in its execute state until done pulses.
- Replaces single-cycle combinational MUL/DIV in the ALU path.

Parameters:
- WIDTH, 32, operand/result width in bits; also the iteration count.
- CW, 6, iteration counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse from the FSM; sampled only in IDLE.
- ALUControl  input  4  operation select from decode; 4'b0100 = MUL, 4'b0111 = DIV.
- SrcA  input  WIDTH  multiplicand / dividend.
- SrcB  input  WIDTH  multiplier / divisor.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result is valid.
- Result  output  WIDTH  product low word, or quotient.
- Rem  output  WIDTH  remainder for DIV; 0 for MUL.
- ALUFlags  output  2  {N, Z} of Result, valid with done and held afterwards.
- DivZero  output  1  set when a DIV completed with SrcB == 0; held until the next accepted start.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: state IDLE, busy=0, done=0, Result=0, Rem=0, ALUFlags=2'b00, DivZero=0, counter=0.
- Reset mid-operation aborts the operation; no done pulse is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 with ALUControl in {0100, 0111} at edge k: latch operands and op, clear DivZero.
  - Next state is RUN, or DONE for DIV with SrcB==0.
  - start with any other ALUControl is ignored; state is unchanged.
- RUN: one iteration per edge, WIDTH iterations at edges k+1..k+WIDTH. At edge k+WIDTH, write Result, Rem and flags and go to DONE.
- DONE: done=1 for exactly one cycle (between edges k+WIDTH and k+WIDTH+1), then IDLE. Total latency is WIDTH+1 cycles from the start sample to the done cycle.
- MUL (shift-add, unsigned):
  - Each step: add the multiplicand when the multiplier LSB is 1; shift the multiplicand left and the multiplier right.
  - Result = low WIDTH bits of the product; the high word is discarded. Rem=0.
- DIV (restoring, unsigned):
  - Each step: shift {rem, dividend} left 1, trial-subtract the divisor, and keep the difference when it is non-negative (quotient bit 1).
  - Result = quotient; Rem = remainder.
- Divide by zero: bypass RUN. Edge k goes to DONE; done is high in cycle k+1. Result = all ones, Rem = SrcA, DivZero=1.
- Flags: N = Result[WIDTH-1]; Z = (Result == 0). Computed from the final value, not from intermediate values.
- start while busy (RUN or DONE) is ignored. The operands and ALUControl may change freely after edge k; the latched copies are used.
- Result, Rem, ALUFlags and DivZero hold their values from the done cycle until the next accepted start.
- Back-to-back operations: the earliest next accepted start is sampled in the cycle after done (IDLE).

Decomposition:
- Shared package holds:
  - ALUControl encodings: ALU_ADD=0000, ALU_SUB=0001, ALU_AND=0010, ALU_ORR=0011, ALU_MUL=0100, ALU_MOV=0101, ALU_DIV=0111.
  - State encodings.
  - WIDTH default.
- One natural sub-module: mdu_step, a combinational single-iteration datapath (mode, accumulator, operand in; next accumulator and operand out).
- The FSM, counter and output registers stay in mdu_iter.

Test Plan:
- Reset then idle: hold reset 2 cycles → busy=0, done=0, Result=0, ALUFlags=00. Pulse start with ALUControl=0010 → no busy, no done.
- MUL: SrcA=7, SrcB=6, start at edge 0 → busy high through edge 32; done only in cycle 33. Result=42, Rem=0, ALUFlags=00.
- MUL overflow and sign: SrcA=0x80000000, SrcB=3 → Result=0x80000000, N=1, Z=0. SrcA=0x10000, SrcB=0x10000 → Result=0, Z=1.
- DIV: SrcA=100, SrcB=7 → Result=14, Rem=2 with done in cycle 33. SrcA=0xFFFFFFFF, SrcB=1 → Result=0xFFFFFFFF, Rem=0, N=1.
- Divide by zero: SrcA=55, SrcB=0 → done in cycle 1, Result=0xFFFFFFFF, Rem=55, DivZero=1. The next valid start clears DivZero.
- Robustness:
  - start held high and operands changed during RUN → ignored; the original result is unchanged.
  - reset asserted at cycle 10 of a DIV → IDLE next edge with all outputs zero and no done pulse.
  - A new MUL 3×5 issued after that completes with Result=15.
